// File: rtl/ksa_pkg.sv
// Shared types and constants for the RC4 key-scheduling engine (ksa_engine).
// Build option: define KSA_SKIP_INIT_EN to add the skip_init port to ksa_engine.
package ksa_pkg;

    typedef enum logic [2:0] {
        ST_IDLE = 3'd0,
        ST_INIT = 3'd1,
        ST_RD_I = 3'd2,
        ST_RD_J = 3'd3,
        ST_WR_I = 3'd4,
        ST_WR_J = 3'd5,
        ST_DONE = 3'd6
    } ksa_state_t;

    // Clock cycles spent on each i during the swap phase (RD_I, RD_J, WR_I, WR_J).
    localparam int unsigned CYCLES_PER_SWAP = 4;

    function automatic int unsigned ksa_depth(input int unsigned data_w);
        return 32'd1 << data_w;
    endfunction

endpackage

// File: rtl/ksa_key_sel.sv
// Key byte selector: latches the key when a schedule starts and steps a wrapping
// byte index k; key byte 0 is the most-significant byte of the key port.
module ksa_key_sel
    import ksa_pkg::*;
#(
    parameter int unsigned DATA_W    = 8,
    parameter int unsigned KEY_BYTES = 3
) (
    input  logic                          clk,
    input  logic                          rst,
    input  logic                          load,
    input  logic                          advance,
    input  logic [KEY_BYTES*DATA_W-1:0]   key,
    output logic [DATA_W-1:0]             key_byte
);

    localparam int unsigned KW = (KEY_BYTES > 1) ? $clog2(KEY_BYTES) : 1;

    logic [KEY_BYTES*DATA_W-1:0] key_q, key_d;
    logic [KW-1:0]               k_q, k_d;

    always_comb begin
        key_d = key_q;
        k_d   = k_q;
        if (load) begin
            key_d = key;
            k_d   = '0;
        end else if (advance) begin
            k_d = (k_q == KW'(KEY_BYTES - 1)) ? '0 : k_q + KW'(1);
        end
    end

    always_ff @(posedge clk) begin
        if (rst) begin
            key_q <= '0;
            k_q   <= '0;
        end else begin
            key_q <= key_d;
            k_q   <= k_d;
        end
    end

    always_comb begin
        key_byte = '0;
        for (int unsigned b = 0; b < KEY_BYTES; b++) begin
            if (k_q == KW'(b)) begin
                key_byte = key_q[(KEY_BYTES-1-b)*DATA_W +: DATA_W];
            end
        end
    end

endmodule

// File: rtl/ksa_engine.sv
// RC4 key-scheduling engine driving one single-port S-memory: identity fill, then swap pass.
// Build option: KSA_SKIP_INIT_EN adds skip_init, which bypasses the identity fill.
module ksa_engine
    import ksa_pkg::*;
#(
    parameter int unsigned DATA_W    = 8,
    parameter int unsigned KEY_BYTES = 3
) (
    input  logic                          clk,
    input  logic                          rst,
    input  logic                          start,
`ifdef KSA_SKIP_INIT_EN
    input  logic                          skip_init,
`endif
    input  logic [KEY_BYTES*DATA_W-1:0]   key,
    output logic [DATA_W-1:0]             mem_addr,
    output logic [DATA_W-1:0]             mem_wdata,
    output logic                          mem_wren,
    input  logic [DATA_W-1:0]             mem_rdata,
    output logic                          busy,
    output logic                          done
);

    localparam int unsigned        DEPTH    = ksa_depth(DATA_W);
    localparam logic [DATA_W-1:0]  LAST_IDX = DATA_W'(DEPTH - 1);

    ksa_state_t          state_q, state_d;
    logic [DATA_W-1:0]   i_q, i_d;
    logic [DATA_W-1:0]   j_q, j_d;
    logic [DATA_W-1:0]   si_q, si_d;
    logic [DATA_W-1:0]   key_byte;
    logic [DATA_W-1:0]   jn;
    logic                key_load;
    logic                key_adv;

    ksa_key_sel #(
        .DATA_W    (DATA_W),
        .KEY_BYTES (KEY_BYTES)
    ) u_key_sel (
        .clk      (clk),
        .rst      (rst),
        .load     (key_load),
        .advance  (key_adv),
        .key      (key),
        .key_byte (key_byte)
    );

    assign jn = j_q + mem_rdata + key_byte;

    always_comb begin
        state_d   = state_q;
        i_d       = i_q;
        j_d       = j_q;
        si_d      = si_q;
        key_load  = 1'b0;
        key_adv   = 1'b0;
        mem_addr  = '0;
        mem_wdata = '0;
        mem_wren  = 1'b0;
        unique case (state_q)
            ST_IDLE: begin
                if (start) begin
                    key_load = 1'b1;
                    i_d      = '0;
                    j_d      = '0;
`ifdef KSA_SKIP_INIT_EN
                    state_d  = skip_init ? ST_RD_I : ST_INIT;
`else
                    state_d  = ST_INIT;
`endif
                end
            end
            ST_INIT: begin
                mem_addr  = i_q;
                mem_wdata = i_q;
                mem_wren  = 1'b1;
                i_d       = i_q + DATA_W'(1);
                if (i_q == LAST_IDX) state_d = ST_RD_I;
            end
            ST_RD_I: begin
                mem_addr = i_q;
                state_d  = ST_RD_J;
            end
            // mem_rdata now holds S[i]; its read for S[jn] is issued in the same cycle.
            ST_RD_J: begin
                si_d     = mem_rdata;
                j_d      = jn;
                mem_addr = jn;
                state_d  = ST_WR_I;
            end
            ST_WR_I: begin
                mem_addr  = i_q;
                mem_wdata = mem_rdata;
                mem_wren  = 1'b1;
                state_d   = ST_WR_J;
            end
            ST_WR_J: begin
                mem_addr  = j_q;
                mem_wdata = si_q;
                mem_wren  = 1'b1;
                i_d       = i_q + DATA_W'(1);
                key_adv   = 1'b1;
                state_d   = (i_q == LAST_IDX) ? ST_DONE : ST_RD_I;
            end
            ST_DONE: state_d = ST_IDLE;
            default: state_d = ST_IDLE;
        endcase
    end

    assign busy = (state_q != ST_IDLE) && (state_q != ST_DONE);
    assign done = (state_q == ST_DONE);

    always_ff @(posedge clk) begin
        if (rst) begin
            state_q <= ST_IDLE;
            i_q     <= '0;
            j_q     <= '0;
            si_q    <= '0;
        end else begin
            state_q <= state_d;
            i_q     <= i_d;
            j_q     <= j_d;
            si_q    <= si_d;
        end
    end

endmodule

// File: tb/tb_ksa_engine.sv
// Bench for ksa_engine: default 8-bit instance plus two 2-bit instances, each with a
// behavioural S-memory; results compared against an RC4 KSA reference in plain arithmetic.
module tb_ksa_engine;

    logic clk = 1'b0;
    logic rst;
    always #5 clk = ~clk;

    // default-parameter instance
    logic        start8;
    logic [23:0] key8;
    logic [7:0]  addr8, wdata8, rdata8;
    logic        wren8, busy8, done8;
    logic [7:0]  mem8 [256];

    // DATA_W=2 instances: "a" has KEY_BYTES=1, "b" has KEY_BYTES=2
    logic        start2a, start2b;
    logic [1:0]  key2a;
    logic [3:0]  key2b;
    logic [1:0]  addr2a, wdata2a, rdata2a, addr2b, wdata2b, rdata2b;
    logic        wren2a, busy2a, done2a, wren2b, busy2b, done2b;
    logic [1:0]  mem2a [4];
    logic [1:0]  mem2b [4];
    logic        pre_we;
    logic [1:0]  pre_addr, pre_data;
`ifdef KSA_SKIP_INIT_EN
    logic        skip8, skip2a, skip2b;
`endif

    ksa_engine u_dut8 (
        .clk(clk), .rst(rst), .start(start8),
`ifdef KSA_SKIP_INIT_EN
        .skip_init(skip8),
`endif
        .key(key8), .mem_addr(addr8), .mem_wdata(wdata8), .mem_wren(wren8),
        .mem_rdata(rdata8), .busy(busy8), .done(done8)
    );

    ksa_engine #(.DATA_W(2), .KEY_BYTES(1)) u_dut2a (
        .clk(clk), .rst(rst), .start(start2a),
`ifdef KSA_SKIP_INIT_EN
        .skip_init(skip2a),
`endif
        .key(key2a), .mem_addr(addr2a), .mem_wdata(wdata2a), .mem_wren(wren2a),
        .mem_rdata(rdata2a), .busy(busy2a), .done(done2a)
    );

    ksa_engine #(.DATA_W(2), .KEY_BYTES(2)) u_dut2b (
        .clk(clk), .rst(rst), .start(start2b),
`ifdef KSA_SKIP_INIT_EN
        .skip_init(skip2b),
`endif
        .key(key2b), .mem_addr(addr2b), .mem_wdata(wdata2b), .mem_wren(wren2b),
        .mem_rdata(rdata2b), .busy(busy2b), .done(done2b)
    );

    // single-port memories: registered read, write committed at the edge
    always @(posedge clk) begin
        if (wren8) mem8[addr8] <= wdata8;
        rdata8 <= mem8[addr8];
    end
    always @(posedge clk) begin
        if (pre_we) mem2a[pre_addr] <= pre_data;
        else if (wren2a) mem2a[addr2a] <= wdata2a;
        rdata2a <= mem2a[addr2a];
    end
    always @(posedge clk) begin
        if (wren2b) mem2b[addr2b] <= wdata2b;
        rdata2b <= mem2b[addr2b];
    end

    int checks = 0;
    int errors = 0;
    int ref_s [256];

    task automatic chk(input string name, input logic [31:0] act, input logic [31:0] exp);
        checks++;
        if (act !== exp) begin
            errors++;
            $display("FAIL %s actual=%0d expected=%0d", name, act, exp);
        end
    endtask

    // RC4 key schedule computed directly from its definition
    function automatic void ksa_ref(input int dw, input int kb, input logic [31:0] k);
        int depth = 1 << dw;
        int j = 0;
        int t, kbyte;
        for (int i = 0; i < depth; i++) ref_s[i] = i;
        for (int i = 0; i < depth; i++) begin
            kbyte = int'(k >> ((kb - 1 - (i % kb)) * dw)) & (depth - 1);
            j = (j + ref_s[i] + kbyte) % depth;
            t = ref_s[i]; ref_s[i] = ref_s[j]; ref_s[j] = t;
        end
    endfunction

    function automatic int img8_bad();
        int n = 0;
        for (int i = 0; i < 256; i++) if (mem8[i] !== 8'(ref_s[i])) n++;
        return n;
    endfunction

    function automatic logic [7:0] ref_img2();
        return {2'(ref_s[0]), 2'(ref_s[1]), 2'(ref_s[2]), 2'(ref_s[3])};
    endfunction

    function automatic logic [7:0] img2(input int which);
        if (which == 0) return {mem2a[0], mem2a[1], mem2a[2], mem2a[3]};
        return {mem2b[0], mem2b[1], mem2b[2], mem2b[3]};
    endfunction

    int   r_done, r_ndone, r_init_bad, r_img_bad;
    logic r_busy_pre, r_busy_at, r_busy_p1, r_busy_p2;

    task automatic run8(input logic [23:0] k, input bit hold, input int rst_at,
                        input int chg_at, input logic [23:0] k2, input int limit);
        logic last_busy = 1'b0;
        bit   stop = 1'b0;
        r_done = -1; r_ndone = 0; r_init_bad = 0; r_img_bad = -1;
        r_busy_pre = 1'b0; r_busy_at = 1'b1; r_busy_p1 = 1'b1; r_busy_p2 = 1'b0;
        ksa_ref(8, 3, {8'd0, k});
        key8 = k;
        start8 = 1'b1;
        for (int c = 1; c <= limit && !stop; c++) begin
            @(posedge clk); #1;
            if (!hold) start8 = 1'b0;
            if (c == chg_at) key8 = k2;
            if (c <= 256 && !(wren8 === 1'b1 && addr8 === 8'(c - 1) && wdata8 === 8'(c - 1)))
                r_init_bad++;
            if (done8) begin
                r_ndone++;
                if (r_done < 0) begin
                    r_done = c; r_busy_pre = last_busy; r_busy_at = busy8; r_img_bad = img8_bad();
                end
            end
            if (r_done > 0 && c == r_done + 1) r_busy_p1 = busy8;
            if (r_done > 0 && c == r_done + 2) r_busy_p2 = busy8;
            last_busy = busy8;
            if (c == rst_at) begin
                rst = 1'b1;
                @(posedge clk); #1;
                chk("rst_mid_outputs", {13'd0, addr8, wdata8, wren8, busy8, done8}, 32'd0);
                rst = 1'b0;
                @(posedge clk); #1;
                chk("rst_mid_idle", {31'd0, busy8}, 32'd0);
                stop = 1'b1;
            end
        end
        start8 = 1'b0;
    endtask

    int d2_done, d2_writes;

    task automatic run2(input int which, input logic [3:0] k, input bit skip);
        d2_done = -1; d2_writes = 0;
        if (which == 0) begin key2a = k[1:0]; start2a = 1'b1; end
        else begin key2b = k; start2b = 1'b1; end
`ifdef KSA_SKIP_INIT_EN
        skip2a = skip; skip2b = skip;
`else
        if (skip) chk("skip_unsupported", 32'd1, 32'd0);
`endif
        for (int c = 1; c <= 60 && d2_done < 0; c++) begin
            @(posedge clk); #1;
            start2a = 1'b0; start2b = 1'b0;
            if (which == 0) begin
                if (wren2a) d2_writes++;
                if (done2a) d2_done = c;
            end else begin
                if (wren2b) d2_writes++;
                if (done2b) d2_done = c;
            end
        end
        @(posedge clk); #1;
    endtask

    typedef struct {
        logic [3:0] key;
        logic [7:0] exp_img;   // {S[0],S[1],S[2],S[3]}
        int         exp_done;
    } vec_t;

    vec_t vecs [4];

    initial begin
        logic [23:0] rk;
        logic [3:0]  k2;
        vecs[0] = '{key: 4'b01_10, exp_img: 8'h39, exp_done: 21};
        vecs[1] = '{key: 4'b00_00, exp_img: 8'h2D, exp_done: 21};
        vecs[2] = '{key: 4'b11_11, exp_img: 8'h4E, exp_done: 21};
        vecs[3] = '{key: 4'b10_00, exp_img: 8'h87, exp_done: 21};

        rst = 1'b1; start8 = 1'b0; start2a = 1'b0; start2b = 1'b0;
        key8 = '0; key2a = '0; key2b = '0;
        pre_we = 1'b0; pre_addr = '0; pre_data = '0;
`ifdef KSA_SKIP_INIT_EN
        skip8 = 1'b0; skip2a = 1'b0; skip2b = 1'b0;
`endif
        repeat (3) @(posedge clk);
        #1 rst = 1'b0;
        chk("reset_outputs", {13'd0, addr8, wdata8, wren8, busy8, done8}, 32'd0);

        // zero key: identity fill timing, done latency and busy/done alignment
        run8(24'h000000, 1'b0, 0, 0, 24'h0, 1290);
        chk("zero_done_cycle", r_done, 32'd1281);
        chk("zero_done_count", r_ndone, 32'd1);
        chk("zero_init_writes", r_init_bad, 32'd0);
        chk("zero_busy_before_done", {31'd0, r_busy_pre}, 32'd1);
        chk("zero_busy_at_done", {31'd0, r_busy_at}, 32'd0);
        chk("zero_image", r_img_bad, 32'd0);

        // start held high, key changed mid-run
        run8(24'h1A2B3C, 1'b1, 0, 700, 24'hFFEEDD, 1290);
        chk("hold_image", r_img_bad, 32'd0);
        chk("hold_done_count", r_ndone, 32'd1);
        chk("hold_idle_after_done", {31'd0, r_busy_p1}, 32'd0);
        chk("hold_restart", {31'd0, r_busy_p2}, 32'd1);
        rst = 1'b1; @(posedge clk); #1 rst = 1'b0;

        // reset during swap phase, then a clean run
        run8(24'hC0FFEE, 1'b0, 600, 0, 24'h0, 700);
        run8(24'h5EED42, 1'b0, 0, 0, 24'h0, 1290);
        chk("post_rst_done_cycle", r_done, 32'd1281);
        chk("post_rst_image", r_img_bad, 32'd0);

        for (int n = 0; n < 2; n++) begin
            rk = 24'($urandom);
            run8(rk, 1'b0, 0, 0, 24'h0, 1290);
            chk("rand8_done_cycle", r_done, 32'd1281);
            chk("rand8_image", r_img_bad, 32'd0);
        end

        for (int v = 0; v < 4; v++) begin
            run2(1, vecs[v].key, 1'b0);
            chk("vec_done_cycle", d2_done, vecs[v].exp_done);
            chk("vec_image", {24'd0, img2(1)}, {24'd0, vecs[v].exp_img});
        end

        run2(0, 4'd0, 1'b0);
        chk("kb1_done_cycle", d2_done, 32'd21);
        chk("kb1_image", {24'd0, img2(0)}, 32'h2D);

        for (int n = 0; n < 10; n++) begin
            k2 = 4'($urandom_range(0, 15));
            ksa_ref(2, 2, {28'd0, k2});
            run2(1, k2, 1'b0);
            chk("rand2_done_cycle", d2_done, 32'd21);
            chk("rand2_image", {24'd0, img2(1)}, {24'd0, ref_img2()});
        end

`ifdef KSA_SKIP_INIT_EN
        for (int a = 0; a < 4; a++) begin
            pre_we = 1'b1; pre_addr = 2'(a); pre_data = 2'(a);
            @(posedge clk); #1;
        end
        pre_we = 1'b0;
        run2(0, 4'd0, 1'b1);
        chk("skip_done_cycle", d2_done, 32'd17);
        chk("skip_write_count", d2_writes, 32'd8);
        chk("skip_image", {24'd0, img2(0)}, 32'h2D);
`endif

        $display("CHECKS %0d ERRORS %0d", checks, errors);
        $finish;
    end

endmodule
